// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: AHB transfer/response encodings and APB sequencer states
package ahb2apb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS} apb_state_t;
endpackage

// File: rtl/ahb2apb_wbuf.sv
// ahb2apb_wbuf: posted-write FIFO of {address, data, slave index}
module ahb2apb_wbuf #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 3,
  parameter int DEPTH = 4
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic [IW-1:0] push_idx,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [IW-1:0] head_idx,
  output logic          full,
  output logic          empty,
  output logic          last
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [IW-1:0] idx_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic do_push, do_pop;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign last = count == (PW+1)'(1);
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_idx = idx_q[rd_ptr];
  always_ff @(posedge HCLK) begin
    if (do_push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
      idx_q[wr_ptr] <= push_idx;
    end
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ahb2apb_posted_bridge.sv
// ahb2apb_posted_bridge: AHB-to-APB bridge with posted writes and in-order reads
module ahb2apb_posted_bridge
  import ahb2apb_pkg::*;
#(
  parameter int NO_OF_SLAVES = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REGION_BITS = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                               HCLK,
  input  logic                               HRESET,
  input  logic                               HSEL,
  input  logic [ADDR_WIDTH-1:0]              HADDR,
  input  logic [1:0]                         HTRANS,
  input  logic                               HWRITE,
  input  logic [DATA_WIDTH-1:0]              HWDATA,
  input  logic                               HREADY,
  output logic                               HREADYOUT,
  output logic                               HRESP,
  output logic [DATA_WIDTH-1:0]              HRDATA,
  output logic [NO_OF_SLAVES-1:0]            PSEL,
  output logic                               PENABLE,
  output logic [ADDR_WIDTH-1:0]              PADDR,
  output logic                               PWRITE,
  output logic [DATA_WIDTH-1:0]              PWDATA,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NO_OF_SLAVES-1:0]            PREADY,
  input  logic [NO_OF_SLAVES-1:0]            PSLVERR,
  output logic                               WERR,
  input  logic                               WERR_CLR
);
  localparam int IW = NO_OF_SLAVES > 1 ? $clog2(NO_OF_SLAVES) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NO_OF_SLAVES) << REGION_BITS;
  apb_state_t state, state_n;
  logic cur_wr, cur_wr_n, wr_dp, rd_pend, err1, err2;
  logic full, empty, last, accept, dec_err, push, pop, done, rd_done, sel_ready, sel_err;
  logic [ADDR_WIDTH-1:0] dp_addr, head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [IW-1:0] dp_idx, head_idx, idx;
  assign accept = HSEL & HREADY & (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign dec_err = {1'b0, HADDR} >= LIMIT;
  assign push = wr_dp & !full;
  // reads only issue once the buffer has drained, so the head entry owns the bus while cur_wr is set
  assign idx = cur_wr ? head_idx : dp_idx;
  assign sel_ready = PREADY[idx];
  assign sel_err = PSLVERR[idx];
  assign done = (state == APB_ACCESS) & sel_ready;
  assign pop = done & cur_wr;
  assign rd_done = done & !cur_wr;
  assign HREADYOUT = !(err1 | rd_pend | (wr_dp & full));
  assign HRESP = (err1 | err2) ? HRESP_ERROR : HRESP_OKAY;
  assign PSEL = (state == APB_IDLE) ? '0 : NO_OF_SLAVES'(1) << idx;
  assign PENABLE = state == APB_ACCESS;
  assign PWRITE = (state != APB_IDLE) & cur_wr;
  assign PADDR = (state == APB_IDLE) ? '0 : cur_wr ? head_addr : dp_addr;
  assign PWDATA = PWRITE ? head_data : '0;
  ahb2apb_wbuf #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH), .IW(IW), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .HCLK(HCLK), .HRESET(HRESET), .push(push), .pop(pop),
    .push_addr(dp_addr), .push_data(HWDATA), .push_idx(dp_idx),
    .head_addr(head_addr), .head_data(head_data), .head_idx(head_idx),
    .full(full), .empty(empty), .last(last)
  );
  always_comb begin
    state_n = state;
    cur_wr_n = cur_wr;
    case (state)
      APB_IDLE: if (!empty || rd_pend) begin
        state_n = APB_SETUP;
        cur_wr_n = !empty;
      end
      APB_SETUP: state_n = APB_ACCESS;
      default: if (sel_ready) begin
        state_n = (cur_wr ? (!last || rd_pend) : !empty) ? APB_SETUP : APB_IDLE;
        cur_wr_n = !cur_wr || !last;
      end
    endcase
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state <= APB_IDLE;
      cur_wr <= 1'b0;
      wr_dp <= 1'b0;
      rd_pend <= 1'b0;
      err1 <= 1'b0;
      err2 <= 1'b0;
      dp_addr <= '0;
      dp_idx <= '0;
      HRDATA <= '0;
      WERR <= 1'b0;
    end else begin
      state <= state_n;
      cur_wr <= cur_wr_n;
      wr_dp <= HREADY ? accept & HWRITE & !dec_err : wr_dp & !push;
      rd_pend <= HREADY ? accept & !HWRITE & !dec_err : rd_pend & !rd_done;
      err1 <= (accept & dec_err) | (rd_done & sel_err);
      err2 <= err1;
      if (accept) begin
        dp_addr <= HADDR;
        dp_idx <= HADDR[REGION_BITS +: IW];
      end
      if (rd_done) HRDATA <= PRDATA[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
      WERR <= (pop & sel_err) | (WERR & !WERR_CLR);
    end
  end
endmodule

// File: tb/tb_ahb2apb_posted_bridge.sv
// tb_ahb2apb_posted_bridge: directed checks of posted writes, ordered reads, errors and reset
module tb_ahb2apb_posted_bridge;
  import ahb2apb_pkg::*;
  logic HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, PENABLE, PWRITE, WERR, WERR_CLR;
  logic [31:0] HADDR, HWDATA, HRDATA, PADDR, PWDATA;
  logic [1:0] HTRANS;
  logic [7:0] PSEL, PREADY, PSLVERR;
  logic [255:0] PRDATA;
  int n_checks = 0, n_errors = 0;
  int psel_cyc = 0, setup_cyc = 0, access_cyc = 0;
  logic [31:0] mon_addr[$], mon_data[$];
  logic [7:0] mon_psel[$];
  logic mon_wr[$];
  assign HREADY = HREADYOUT;
  ahb2apb_posted_bridge dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .WERR(WERR), .WERR_CLR(WERR_CLR)
  );
  initial HCLK = 0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) begin
    if (!HRESET && |PSEL) begin
      psel_cyc <= psel_cyc + 1;
      if (!PENABLE) setup_cyc <= setup_cyc + 1;
      else access_cyc <= access_cyc + 1;
      for (int k = 0; k < 8; k++)
        if (PSEL[k] && PENABLE && PREADY[k]) begin
          mon_addr.push_back(PADDR);
          mon_data.push_back(PWRITE ? PWDATA : PRDATA[k*32 +: 32]);
          mon_psel.push_back(PSEL);
          mon_wr.push_back(PWRITE);
        end
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic ahb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic resp, output logic resp0, output int waits);
    HSEL = 1; HADDR = addr; HWRITE = wr; HTRANS = HTRANS_NONSEQ;
    @(negedge HCLK);
    HSEL = 0; HTRANS = HTRANS_IDLE; HWDATA = wdata;
    resp0 = HRESP;
    waits = 0;
    while (!HREADYOUT && waits < 200) begin
      waits++;
      @(negedge HCLK);
    end
    if (waits >= 200) check("hready_timeout", HREADYOUT, 1);
    resp = HRESP;
    rdata = HRDATA;
  endtask
  task automatic wait_apb(input int n);
    int k = 0;
    while (mon_addr.size() < n && k < 100) begin
      @(negedge HCLK);
      k++;
    end
    check("apb_timeout", mon_addr.size() >= n, 1);
  endtask
  task automatic wait_access();
    int k = 0;
    while (!PENABLE && k < 50) begin
      @(negedge HCLK);
      k++;
    end
    check("reach_access", PENABLE, 1);
  endtask
  logic [31:0] rd;
  logic rs, r0;
  int w, b, sb, ab;
  initial begin
    HRESET = 1; HSEL = 0; HADDR = 0; HTRANS = HTRANS_IDLE; HWRITE = 0; HWDATA = 0;
    PREADY = '1; PSLVERR = '0; WERR_CLR = 0;
    for (int k = 0; k < 8; k++) PRDATA[k*32 +: 32] = 32'hA000_0000 | k;
    PRDATA[3*32 +: 32] = 32'h1234_5678;
    repeat (3) @(negedge HCLK);
    check("rst_hreadyout", HREADYOUT, 1);
    check("rst_hresp", HRESP, 0);
    check("rst_hrdata", HRDATA, 0);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_werr", WERR, 0);
    HRESET = 0;
    @(negedge HCLK);
    b = psel_cyc;
    HSEL = 1; HADDR = 32'h100; HWRITE = 1; HTRANS = HTRANS_BUSY;
    @(negedge HCLK);
    check("busy_ready", HREADYOUT, 1);
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    check("idle_resp", {HREADYOUT, HRESP}, 2'b10);
    HSEL = 0;
    repeat (4) @(negedge HCLK);
    check("busy_idle_no_apb", psel_cyc - b, 0);
    b = mon_addr.size(); sb = setup_cyc; ab = access_cyc;
    ahb_xfer(1, 32'h104, 32'hA5A5_A5A5, rd, rs, r0, w);
    check("w104_waits", w, 0);
    check("w104_resp", rs, 0);
    wait_apb(b + 1);
    check("w104_paddr", mon_addr[b], 32'h104);
    check("w104_pwdata", mon_data[b], 32'hA5A5_A5A5);
    check("w104_pwrite", mon_wr[b], 1);
    check("w104_psel", mon_psel[b], 8'h02);
    check("w104_setup_cycles", setup_cyc - sb, 1);
    check("w104_access_cycles", access_cyc - ab, 1);
    b = mon_addr.size();
    PREADY[0] = 0;
    fork
      begin
        repeat (10) @(negedge HCLK);
        PREADY[0] = 1;
      end
    join_none
    for (int i = 0; i < 5; i++) begin
      ahb_xfer(1, 32'(i * 4), 32'hD000_0000 + 32'(i), rd, rs, r0, w);
      if (i < 4) check($sformatf("b2b_wait%0d", i), w, 0);
      else begin
        check("b2b_fifth_stalled", w > 0, 1);
        check("b2b_fifth_after_pop", mon_addr.size() - b, 1);
      end
    end
    wait_apb(b + 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b2b_addr%0d", i), mon_addr[b + i], 32'(i * 4));
      check($sformatf("b2b_data%0d", i), mon_data[b + i], 32'hD000_0000 + 32'(i));
    end
    b = mon_addr.size();
    ahb_xfer(1, 32'h300, 32'hCAFE_0001, rd, rs, r0, w);
    ahb_xfer(0, 32'h308, 32'h0, rd, rs, r0, w);
    check("r308_rdata", rd, 32'h1234_5678);
    check("r308_resp", rs, 0);
    check("r308_waited", w > 0, 1);
    wait_apb(b + 2);
    check("order_first_write", {mon_wr[b], mon_addr[b]}, {1'b1, 32'h300});
    check("order_then_read", {mon_wr[b + 1], mon_addr[b + 1]}, {1'b0, 32'h308});
    check("r308_psel", mon_psel[b + 1], 8'h08);
    b = mon_addr.size();
    ahb_xfer(0, 32'h7FC, 32'h0, rd, rs, r0, w);
    check("r7fc_rdata", rd, 32'hA000_0007);
    check("r7fc_resp", rs, 0);
    wait_apb(b + 1);
    check("r7fc_psel", mon_psel[b], 8'h80);
    b = psel_cyc;
    ahb_xfer(0, 32'h800, 32'h0, rd, rs, r0, w);
    check("r800_resp_first", r0, 1);
    check("r800_resp_final", rs, 1);
    check("r800_waits", w, 1);
    ahb_xfer(1, 32'hFFFF_0000, 32'h1, rd, rs, r0, w);
    check("wbad_resp", {r0, rs}, 2'b11);
    check("wbad_waits", w, 1);
    repeat (4) @(negedge HCLK);
    check("decerr_no_apb", psel_cyc - b, 0);
    PSLVERR[2] = 1;
    b = mon_addr.size();
    ahb_xfer(1, 32'h200, 32'h5555_5555, rd, rs, r0, w);
    check("w200_resp", rs, 0);
    check("w200_waits", w, 0);
    wait_apb(b + 1);
    check("werr_set", WERR, 1);
    repeat (3) @(negedge HCLK);
    check("werr_sticky", WERR, 1);
    WERR_CLR = 1;
    @(negedge HCLK);
    WERR_CLR = 0;
    check("werr_cleared", WERR, 0);
    PREADY[2] = 0;
    ahb_xfer(1, 32'h204, 32'h6666_6666, rd, rs, r0, w);
    wait_access();
    PREADY[2] = 1; WERR_CLR = 1;
    @(negedge HCLK);
    WERR_CLR = 0;
    check("werr_set_beats_clr", WERR, 1);
    WERR_CLR = 1;
    @(negedge HCLK);
    WERR_CLR = 0;
    check("werr_cleared2", WERR, 0);
    ahb_xfer(0, 32'h208, 32'h0, rd, rs, r0, w);
    check("r208_slverr_resp", rs, 1);
    PSLVERR = '0;
    check("read_err_no_werr", WERR, 0);
    PREADY[1] = 0;
    for (int i = 0; i < 4; i++) begin
      ahb_xfer(1, 32'h100 + 32'(i * 4), 32'hB000_0000 + 32'(i), rd, rs, r0, w);
      check($sformatf("rst_fill_wait%0d", i), w, 0);
    end
    wait_access();
    HRESET = 1;
    #1;
    check("midrst_psel", PSEL, 0);
    check("midrst_penable", PENABLE, 0);
    check("midrst_hreadyout", HREADYOUT, 1);
    @(negedge HCLK);
    HRESET = 0;
    PREADY = '1;
    b = psel_cyc; sb = mon_addr.size();
    repeat (20) @(negedge HCLK);
    check("midrst_no_apb", psel_cyc - b, 0);
    check("midrst_no_xfers", mon_addr.size() - sb, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
